// File: rtl/if_id_stage_pkg.sv
// Shared constants and FSM encoding for the DLX fetch front end (if_id_stage and next_pc_sel).
package dlx_fetch_pkg;

  localparam int DEF_ADDR_W  = 10;
  localparam int DEF_INSTR_W = 32;
  localparam logic [DEF_INSTR_W-1:0] NOP_INSTR = 32'h0000_0000;

  typedef enum logic {
    RUN        = 1'b0,
    HOLD_REDIR = 1'b1
  } fetch_state_e;

endpackage

// File: rtl/if_id_stage_if.sv
// Fetch-stage bus: PC/instruction-memory handshake, hazard controls and the IF/ID register outputs.
interface if_id_stage_if #(
  parameter int ADDR_W  = 10,
  parameter int INSTR_W = 32
);
  logic [ADDR_W-1:0]  PC_current;
  logic [INSTR_W-1:0] instr_in;
  logic               stall;
  logic               redirect_valid;
  logic [ADDR_W-1:0]  redirect_target;
  logic [ADDR_W-1:0]  PC_new;
  logic               PC_write;
  logic [ADDR_W-1:0]  if_id_pc_plus1;
  logic [INSTR_W-1:0] if_id_instr;
  logic               if_id_valid;

  // master: the fetch stage itself; slave: PC, instruction memory and decode around it
  modport master (
    input  PC_current, instr_in, stall, redirect_valid, redirect_target,
    output PC_new, PC_write, if_id_pc_plus1, if_id_instr, if_id_valid
  );

  modport slave (
    output PC_current, instr_in, stall, redirect_valid, redirect_target,
    input  PC_new, PC_write, if_id_pc_plus1, if_id_instr, if_id_valid
  );
endinterface

// File: rtl/if_id_stage_next_pc_sel.sv
// Combinational next-PC selection: chooses PC_new and the PC load enable from state, stall and redirect.
module next_pc_sel
  import dlx_fetch_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  fetch_state_e      state,
  input  logic              reset,
  input  logic              stall,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] pc_current,
  input  logic [ADDR_W-1:0] pc_plus1,
  input  logic [ADDR_W-1:0] redirect_target,
  input  logic [ADDR_W-1:0] pend_target,
  output logic [ADDR_W-1:0] pc_new,
  output logic              pc_write
);

  always_comb begin
    pc_write = 1'b0;
    pc_new   = pc_current;
    if (reset) begin
      pc_write = 1'b1;
      pc_new   = '0;
    end else if (!stall) begin
      pc_write = 1'b1;
      // A fresh redirect always beats an older pending one
      if (redirect_valid)
        pc_new = redirect_target;
      else if (state == HOLD_REDIR)
        pc_new = pend_target;
      else
        pc_new = pc_plus1;
    end
  end

endmodule

// File: rtl/if_id_stage.sv
// IF/ID pipeline register and fetch front-end FSM (RUN / HOLD_REDIR) for the DLX core.
// Optional build macro IFID_PERF_CNT_EN adds saturating fetch_cnt / bubble_cnt outputs.
module if_id_stage
  import dlx_fetch_pkg::*;
#(
  parameter int                 ADDR_W  = DEF_ADDR_W,
  parameter int                 INSTR_W = DEF_INSTR_W,
  parameter logic [INSTR_W-1:0] NOP     = NOP_INSTR
) (
  input  logic          clock,
  input  logic          reset,
  if_id_stage_if.master bus
`ifdef IFID_PERF_CNT_EN
  ,
  output logic [31:0]   fetch_cnt,
  output logic [31:0]   bubble_cnt
`endif
);

  fetch_state_e       state, nxt_state;
  logic [ADDR_W-1:0]  pend_target, nxt_pend;
  logic [ADDR_W-1:0]  pc_plus1_p0;
  logic               latch_en;
  logic [ADDR_W-1:0]  latch_pc;
  logic [INSTR_W-1:0] latch_instr;
  logic               latch_vld;
  logic [ADDR_W-1:0]  pc_plus1_p1;
  logic [INSTR_W-1:0] instr_p1;
  logic               vld_p1;

  // ---- stage p0: fetch address arithmetic and next-PC choice ----
  assign pc_plus1_p0 = bus.PC_current + ADDR_W'(1);

  next_pc_sel #(.ADDR_W(ADDR_W)) u_next_pc_sel (
    .state           (state),
    .reset           (reset),
    .stall           (bus.stall),
    .redirect_valid  (bus.redirect_valid),
    .pc_current      (bus.PC_current),
    .pc_plus1        (pc_plus1_p0),
    .redirect_target (bus.redirect_target),
    .pend_target     (pend_target),
    .pc_new          (bus.PC_new),
    .pc_write        (bus.PC_write)
  );

  always_comb begin
    nxt_state   = state;
    nxt_pend    = pend_target;
    latch_en    = 1'b0;
    latch_pc    = pc_plus1_p1;
    latch_instr = NOP;
    latch_vld   = 1'b0;
    unique case (state)
      RUN: begin
        if (!bus.stall) begin
          latch_en = 1'b1;
          latch_pc = pc_plus1_p0;
          if (!bus.redirect_valid) begin
            latch_instr = bus.instr_in;
            latch_vld   = 1'b1;
          end
        end else if (bus.redirect_valid) begin
          // Redirect under stall: park the target, bubble IF/ID with its pc left alone
          latch_en  = 1'b1;
          nxt_pend  = bus.redirect_target;
          nxt_state = HOLD_REDIR;
        end
      end
      HOLD_REDIR: begin
        if (bus.stall) begin
          if (bus.redirect_valid)
            nxt_pend = bus.redirect_target;
        end else begin
          latch_en  = 1'b1;
          nxt_state = RUN;
        end
      end
      default: nxt_state = RUN;
    endcase
  end

  // ---- stage p1: IF/ID register and FSM state ----
  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= RUN;
      pend_target <= '0;
      pc_plus1_p1 <= '0;
      instr_p1    <= NOP;
      vld_p1      <= 1'b0;
    end else begin
      state       <= nxt_state;
      pend_target <= nxt_pend;
      if (latch_en) begin
        pc_plus1_p1 <= latch_pc;
        instr_p1    <= latch_instr;
        vld_p1      <= latch_vld;
      end
    end
  end

  assign bus.if_id_pc_plus1 = pc_plus1_p1;
  assign bus.if_id_instr    = instr_p1;
  assign bus.if_id_valid    = vld_p1;

`ifdef IFID_PERF_CNT_EN
  function automatic logic [31:0] sat_inc32(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  always_ff @(posedge clock) begin
    if (reset) begin
      fetch_cnt  <= '0;
      bubble_cnt <= '0;
    end else if (latch_en) begin
      if (latch_vld)
        fetch_cnt  <= sat_inc32(fetch_cnt);
      else
        bubble_cnt <= sat_inc32(bubble_cnt);
    end
  end
`endif

endmodule

// File: tb/tb_if_id_stage.sv
// Scoreboard bench for if_id_stage: directed fetch scenarios followed by randomized stall/redirect/reset traffic.
module tb_if_id_stage;
  localparam int AW = 10;
  localparam int IW = 32;

  typedef struct {
    logic [AW-1:0] pc;
    logic [IW-1:0] instr;
    logic          vld;
    logic [31:0]   fc;
    logic [31:0]   bc;
  } exp_t;

  logic clock;
  logic reset;
  logic [AW-1:0] pc_reg;
  int total;
  int bad;
  exp_t q[$];

  // reference model state
  bit          m_pending;
  logic [AW-1:0] m_pend;
  exp_t        m_ifid;

  if_id_stage_if #(.ADDR_W(AW), .INSTR_W(IW)) bus ();

`ifdef IFID_PERF_CNT_EN
  logic [31:0] fetch_cnt;
  logic [31:0] bubble_cnt;
  if_id_stage dut (.clock(clock), .reset(reset), .bus(bus),
                   .fetch_cnt(fetch_cnt), .bubble_cnt(bubble_cnt));
`else
  if_id_stage dut (.clock(clock), .reset(reset), .bus(bus));
`endif

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Environment: program counter register and an instruction memory holding 4*address
  initial pc_reg = '0;
  always @(posedge clock) if (bus.PC_write) pc_reg <= bus.PC_new;
  assign bus.PC_current = pc_reg;
  assign bus.instr_in   = 32'(pc_reg) * 32'd4;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  function automatic logic [31:0] sat(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  // One clock cycle of stimulus: drive, check next-PC outputs, predict IF/ID after the edge
  task automatic step(input logic rst, input logic st, input logic rv, input logic [AW-1:0] tgt);
    logic          e_we;
    logic [AW-1:0] e_new;
    logic [AW-1:0] pc;
    @(negedge clock);
    reset              = rst;
    bus.stall          = st;
    bus.redirect_valid = rv;
    bus.redirect_target = tgt;
    #1;
    pc    = bus.PC_current;
    e_we  = 1'b0;
    e_new = pc;
    if (rst) begin
      e_we = 1'b1;
      e_new = '0;
      m_pending = 0;
      m_pend = '0;
      m_ifid = '{pc: '0, instr: 32'h0, vld: 1'b0, fc: 32'd0, bc: 32'd0};
    end else if (!st) begin
      e_we = 1'b1;
      if (m_pending) begin
        e_new = rv ? tgt : m_pend;
        m_pending = 0;
        m_ifid.instr = 32'h0;
        m_ifid.vld = 1'b0;
        m_ifid.bc = sat(m_ifid.bc);
      end else if (rv) begin
        e_new = tgt;
        m_ifid.pc = AW'((32'(pc) + 1) % 1024);
        m_ifid.instr = 32'h0;
        m_ifid.vld = 1'b0;
        m_ifid.bc = sat(m_ifid.bc);
      end else begin
        e_new = AW'((32'(pc) + 1) % 1024);
        m_ifid.pc = e_new;
        m_ifid.instr = 32'(pc) * 32'd4;
        m_ifid.vld = 1'b1;
        m_ifid.fc = sat(m_ifid.fc);
      end
    end else if (rv) begin
      if (!m_pending) begin
        m_ifid.instr = 32'h0;
        m_ifid.vld = 1'b0;
        m_ifid.bc = sat(m_ifid.bc);
      end
      m_pending = 1;
      m_pend = tgt;
    end
    chk("PC_write", 32'(bus.PC_write), 32'(e_we));
    if (e_we) chk("PC_new", 32'(bus.PC_new), 32'(e_new));
    q.push_back(m_ifid);
  endtask

  // Monitor: the IF/ID register presents a new value after every edge
  always @(posedge clock) begin
    exp_t e;
    #1;
    if (q.size() > 0) begin
      e = q.pop_front();
      chk("if_id_valid", 32'(bus.if_id_valid), 32'(e.vld));
      chk("if_id_instr", bus.if_id_instr, e.instr);
      chk("if_id_pc_plus1", 32'(bus.if_id_pc_plus1), 32'(e.pc));
`ifdef IFID_PERF_CNT_EN
      chk("fetch_cnt", fetch_cnt, e.fc);
      chk("bubble_cnt", bubble_cnt, e.bc);
`endif
    end
  end

  initial begin
    total = 0;
    bad = 0;
    m_pending = 0;
    m_pend = '0;
    m_ifid = '{pc: '0, instr: 32'h0, vld: 1'b0, fc: 32'd0, bc: 32'd0};
    reset = 1'b1;
    bus.stall = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_target = '0;

    // reset then sequential fetch
    repeat (2) step(1, 0, 0, '0);
    repeat (6) step(0, 0, 0, '0);
    // address wrap at the top of memory
    step(0, 0, 1, 10'h3FF);
    repeat (3) step(0, 0, 0, '0);
    // redirect at PC=5 to 0x040
    step(0, 0, 1, 10'd5);
    step(0, 0, 1, 10'h040);
    repeat (3) step(0, 0, 0, '0);
    // three-cycle stall at PC=8
    step(0, 0, 1, 10'd8);
    step(0, 0, 0, '0);
    step(0, 0, 1, 10'd8);
    repeat (3) step(0, 1, 0, '0);
    repeat (2) step(0, 0, 0, '0);
    // two redirects while stalled; the younger one wins
    step(0, 1, 1, 10'h100);
    step(0, 1, 1, 10'h200);
    step(0, 1, 0, '0);
    step(0, 0, 0, '0);
    repeat (3) step(0, 0, 0, '0);
    // redirect on the release cycle itself
    step(0, 1, 1, 10'h0AA);
    step(0, 0, 1, 10'h0BB);
    repeat (2) step(0, 0, 0, '0);
    // reset while a redirect is pending
    step(0, 1, 1, 10'h123);
    step(1, 0, 0, '0);
    repeat (3) step(0, 0, 0, '0);

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 99) == 0), ($urandom_range(0, 3) == 0),
           ($urandom_range(0, 6) == 0), AW'($urandom));
    end
    step(0, 0, 0, '0);
    @(posedge clock);
    #3;
    chk("scoreboard_drained", 32'(q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
